// File: rtl/fsm_pattern_sequencer.sv
// Capture/replay sequencer for the Moore/Mealy pattern-detector exercise.
// Captures CAPTURE_LEN button samples on a slow strobe, replays them into two detectors and counts hits.
module fsm_pattern_sequencer #(
    parameter int DIVIDER_WIDTH = 24,
    parameter int CAPTURE_LEN   = 10,
    parameter int COUNT_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   button,
    input  logic                   moore_hit,
    input  logic                   mealy_hit,
    output logic                   strobe,
    output logic                   pattern_bit,
    output logic                   det_reset_n,
    output logic [CAPTURE_LEN-1:0] capture_data,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] moore_count,
    output logic [COUNT_WIDTH-1:0] mealy_count
);

    localparam int BW = $clog2(CAPTURE_LEN + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CAPTURE_LEN - 1);
    localparam logic [BW-1:0] ALL_BITS = BW'(CAPTURE_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_REPLAY,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [DIVIDER_WIDTH-1:0] div_q, div_d;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [CAPTURE_LEN-1:0]   cap_q, cap_d;
    logic [CAPTURE_LEN-1:0]   rep_q, rep_d;
    logic [COUNT_WIDTH-1:0]   moore_cnt_q, moore_cnt_d;
    logic [COUNT_WIDTH-1:0]   mealy_cnt_q, mealy_cnt_d;
    logic                     post_strobe_q, post_strobe_d;
    logic                     det_rst_n_q, det_rst_n_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     tick;

    assign tick   = &div_q;
    assign strobe = (state_q == S_REPLAY) && tick;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d       = state_q;
        div_d         = div_q + 1'b1;
        bit_cnt_d     = bit_cnt_q;
        cap_d         = cap_q;
        rep_d         = rep_q;
        moore_cnt_d   = moore_cnt_q;
        mealy_cnt_d   = mealy_cnt_q;
        post_strobe_d = strobe;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (start) begin
                    moore_cnt_d = '0;
                    mealy_cnt_d = '0;
                    cap_d       = '0;
                    bit_cnt_d   = '0;
                    state_d     = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (tick) begin
                    cap_d = {button, cap_q[CAPTURE_LEN-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        rep_d     = {button, cap_q[CAPTURE_LEN-1:1]};
                        bit_cnt_d = '0;
                        div_d     = '0;
                        state_d   = S_REPLAY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_REPLAY: begin
                if (strobe) begin
                    rep_d     = rep_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (mealy_hit && !(&mealy_cnt_q)) mealy_cnt_d = mealy_cnt_q + 1'b1;
                end
                // Moore output reflects the bit shifted in on the previous strobe.
                if (post_strobe_q && moore_hit && !(&moore_cnt_q)) moore_cnt_d = moore_cnt_q + 1'b1;
                if (bit_cnt_q == ALL_BITS) state_d = S_DONE;
            end
            S_DONE: begin
                div_d     = '0;
                bit_cnt_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        busy_d      = (state_d == S_CAPTURE) || (state_d == S_REPLAY);
        done_d      = (state_d == S_DONE);
        det_rst_n_d = (state_d == S_REPLAY);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_cnt_q     <= '0;
            cap_q         <= '0;
            rep_q         <= '0;
            moore_cnt_q   <= '0;
            mealy_cnt_q   <= '0;
            post_strobe_q <= 1'b0;
            det_rst_n_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_cnt_q     <= bit_cnt_d;
            cap_q         <= cap_d;
            rep_q         <= rep_d;
            moore_cnt_q   <= moore_cnt_d;
            mealy_cnt_q   <= mealy_cnt_d;
            post_strobe_q <= post_strobe_d;
            det_rst_n_q   <= det_rst_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign pattern_bit  = rep_q[0];
    assign det_reset_n  = det_rst_n_q;
    assign capture_data = cap_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign moore_count  = moore_cnt_q;
    assign mealy_count  = mealy_cnt_q;

endmodule

// File: tb/tb_fsm_pattern_sequencer.sv
// Bench for fsm_pattern_sequencer: directed and random runs against a cycle-numbered reference model.
// A second instance with 2-bit counters exercises saturation on the same stimulus.
module tb_fsm_pattern_sequencer;

    localparam int W        = 2;
    localparam int L        = 10;
    localparam int CW       = 4;
    localparam int CW_SAT   = 2;
    localparam int PERIOD   = 1 << W;
    localparam int REP_BASE = L * PERIOD;
    localparam int DONE_CYC = 2 * L * PERIOD + 2;

    logic          clock, reset, start, button, moore_hit, mealy_hit;
    logic          strobe, pattern_bit, det_reset_n, busy, done;
    logic [L-1:0]  capture_data;
    logic [CW-1:0] moore_count, mealy_count;

    logic              s_strobe, s_pattern_bit, s_det_reset_n, s_busy, s_done;
    logic [L-1:0]      s_capture_data;
    logic [CW_SAT-1:0] s_moore_count, s_mealy_count;

    int total = 0;
    int bad   = 0;

    fsm_pattern_sequencer #(.DIVIDER_WIDTH(W), .CAPTURE_LEN(L), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .start(start), .button(button),
        .moore_hit(moore_hit), .mealy_hit(mealy_hit),
        .strobe(strobe), .pattern_bit(pattern_bit), .det_reset_n(det_reset_n),
        .capture_data(capture_data), .busy(busy), .done(done),
        .moore_count(moore_count), .mealy_count(mealy_count)
    );

    fsm_pattern_sequencer #(.DIVIDER_WIDTH(W), .CAPTURE_LEN(L), .COUNT_WIDTH(CW_SAT)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .button(button),
        .moore_hit(moore_hit), .mealy_hit(mealy_hit),
        .strobe(s_strobe), .pattern_bit(s_pattern_bit), .det_reset_n(s_det_reset_n),
        .capture_data(s_capture_data), .busy(s_busy), .done(s_done),
        .moore_count(s_moore_count), .mealy_count(s_mealy_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stand-in "01" detectors: Mealy output is combinational, Moore output is registered.
    logic prev0, moore_y;
    logic noise_mode, nz_moore, nz_mealy;

    always @(posedge clock or negedge det_reset_n) begin
        if (!det_reset_n) begin
            prev0   <= 1'b0;
            moore_y <= 1'b0;
        end else if (strobe) begin
            moore_y <= prev0 & pattern_bit;
            prev0   <= ~pattern_bit;
        end
    end

    assign mealy_hit = noise_mode ? nz_mealy : (det_reset_n & prev0 & pattern_bit);
    assign moore_hit = noise_mode ? nz_moore : moore_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int w);
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_drn"}, det_reset_n, 0);
        check({tag, "_strobe"}, strobe, 0);
        check({tag, "_pbit"}, pattern_bit, 0);
        check({tag, "_cap"}, capture_data, 0);
        check({tag, "_moore"}, moore_count, 0);
        check({tag, "_mealy"}, mealy_count, 0);
        check({tag, "_s_moore"}, s_moore_count, 0);
        check({tag, "_s_mealy"}, s_mealy_count, 0);
    endtask

    // One full run; bits[i] is the i-th oldest button sample. abort_at > 0 asserts reset in that cycle.
    task automatic run(input logic [L-1:0] bits, input bit noise, input bit start_noise, input int abort_at);
        int  n01;
        int  exp_mealy;
        int  exp_moore;
        int  rk;
        bit  exp_busy, exp_done, exp_drn, exp_strobe, moore_slot;
        bit  aborted;
        n01       = 0;
        exp_mealy = 0;
        exp_moore = 0;
        aborted   = 0;
        for (int i = 1; i < L; i++) if (!bits[i-1] && bits[i]) n01++;
        noise_mode = noise;

        start  = 1'b1;
        button = 1'($urandom);
        @(posedge clock);
        #1;
        start = 1'b0;

        for (int cyc = 1; cyc <= DONE_CYC + 2; cyc++) begin
            if (cyc == abort_at) begin
                reset = 1'b1;
                #1;
                check_idle_zero($sformatf("abort@%0d", cyc));
                check($sformatf("abort_s_drn@%0d", cyc), s_det_reset_n, 0);
                @(posedge clock);
                #1;
                reset = 1'b0;
                for (int j = 0; j < 3 * PERIOD * 2; j++) begin
                    check($sformatf("post_abort_done@%0d", j), done, 0);
                    check($sformatf("post_abort_busy@%0d", j), busy, 0);
                    @(posedge clock);
                    #1;
                end
                aborted = 1;
                break;
            end

            rk         = cyc - REP_BASE;
            exp_busy   = (cyc <= DONE_CYC - 1);
            exp_done   = (cyc == DONE_CYC);
            exp_drn    = (cyc >= REP_BASE + 1) && (cyc <= DONE_CYC - 1);
            exp_strobe = (rk > 0) && (rk % PERIOD == 0) && (rk / PERIOD <= L);
            moore_slot = (rk > 1) && ((rk - 1) % PERIOD == 0) && ((rk - 1) / PERIOD <= L);

            check($sformatf("busy@%0d", cyc), busy, exp_busy);
            check($sformatf("done@%0d", cyc), done, exp_done);
            check($sformatf("det_reset_n@%0d", cyc), det_reset_n, exp_drn);
            check($sformatf("strobe@%0d", cyc), strobe, exp_strobe);
            check($sformatf("s_done@%0d", cyc), s_done, exp_done);
            check($sformatf("s_busy@%0d", cyc), s_busy, exp_busy);
            check($sformatf("s_drn@%0d", cyc), s_det_reset_n, exp_drn);
            check($sformatf("s_strobe@%0d", cyc), s_strobe, exp_strobe);
            if (exp_strobe) begin
                check($sformatf("pattern_bit@%0d", cyc), pattern_bit, bits[rk/PERIOD-1]);
                check($sformatf("s_pattern_bit@%0d", cyc), s_pattern_bit, bits[rk/PERIOD-1]);
            end
            if (cyc == 1) begin
                check("start_clears_cap", capture_data, 0);
                check("start_clears_moore", moore_count, 0);
                check("start_clears_mealy", mealy_count, 0);
            end

            start = (cyc <= DONE_CYC) &&
                    (cyc == 5 || cyc == 50 || (start_noise && $urandom_range(0, 7) == 0));
            if (cyc <= REP_BASE && cyc % PERIOD == 0) button = bits[cyc/PERIOD-1];
            else                                      button = 1'($urandom);
            nz_mealy = 1'($urandom);
            nz_moore = 1'($urandom);
            if (noise && exp_strobe && nz_mealy) exp_mealy++;
            if (noise && moore_slot && nz_moore) exp_moore++;

            @(posedge clock);
            #1;
        end
        start = 1'b0;

        if (!aborted) begin
            if (!noise) begin
                exp_mealy = n01;
                exp_moore = n01;
            end
            check("capture_data", capture_data, bits);
            check("s_capture_data", s_capture_data, bits);
            check("moore_count", moore_count, sat(exp_moore, CW));
            check("mealy_count", mealy_count, sat(exp_mealy, CW));
            check("s_moore_count", s_moore_count, sat(exp_moore, CW_SAT));
            check("s_mealy_count", s_mealy_count, sat(exp_mealy, CW_SAT));
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        button     = 1'b0;
        noise_mode = 1'b0;
        nz_moore   = 1'b0;
        nz_mealy   = 1'b0;
        #3;
        check_idle_zero("reset");
        check("reset_s_drn", s_det_reset_n, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        run(10'h39A, 1'b0, 1'b0, 0);
        run(10'h3FF, 1'b0, 1'b0, 0);
        run(10'h2AA, 1'b0, 1'b0, 0);
        for (int r = 0; r < 3; r++) run(10'($urandom), 1'b0, 1'b1, 0);
        for (int r = 0; r < 2; r++) run(10'($urandom), 1'b1, 1'b1, 0);
        run(10'h39A, 1'b0, 1'b0, 60);
        run(10'($urandom), 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
